// File: rtl/keypoint_window_gen.sv
// Streaming 3x3 window generator: buffers two previous lines of raster pixels and emits
// one neighbourhood per interior pixel, with centre coordinates, through a single output stage.
module keypoint_window_gen #(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned XW         = $clog2(IMG_WIDTH),
  parameter int unsigned YW         = $clog2(IMG_HEIGHT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_valid,
  input  logic [7:0]    pix_data,
  input  logic          pix_sof,
  output logic          pix_ready,
  output logic          win_valid,
  input  logic          win_ready,
  output logic [23:0]   win_row_0,
  output logic [23:0]   win_row_1,
  output logic [23:0]   win_row_2,
  output logic [XW-1:0] win_x,
  output logic [YW-1:0] win_y,
  output logic          frame_done
);

  logic [XW-1:0] r_col;
  logic [YW-1:0] r_row;
  logic [7:0]    r_lb0 [IMG_WIDTH];
  logic [7:0]    r_lb1 [IMG_WIDTH];
  logic [15:0]   r_hist_top, r_hist_mid, r_hist_btm;
  logic          r_win_valid;
  logic [23:0]   r_win_row_0, r_win_row_1, r_win_row_2;
  logic [XW-1:0] r_win_x;
  logic [YW-1:0] r_win_y;
  logic          r_frame_done;

  logic          w_accept;
  logic          w_emit;
  logic          w_col_wrap;
  logic [XW-1:0] w_c;
  logic [YW-1:0] w_r;
  logic [XW-1:0] w_col_nxt;
  logic [YW-1:0] w_row_nxt;
  logic [7:0]    w_lb0_rd, w_lb1_rd;
  logic [23:0]   w_top_nxt, w_mid_nxt, w_btm_nxt;

  assign pix_ready = ~r_win_valid | win_ready;
  assign w_accept  = pix_valid & pix_ready;

  // A start-of-frame pixel is always (0,0), whatever the counters say
  assign w_c = pix_sof ? '0 : r_col;
  assign w_r = pix_sof ? '0 : r_row;

  assign w_emit     = w_accept && (w_c >= XW'(2)) && (w_r >= YW'(2));
  assign w_col_wrap = (w_c == XW'(IMG_WIDTH - 1));
  assign w_col_nxt  = w_col_wrap ? '0 : w_c + XW'(1);
  assign w_row_nxt  = !w_col_wrap ? w_r :
                      (w_r == YW'(IMG_HEIGHT - 1)) ? '0 : w_r + YW'(1);

  assign w_lb0_rd = r_lb0[w_c];
  assign w_lb1_rd = r_lb1[w_c];

  // History regs keep the two older columns; the newest column is joined on the fly
  assign w_top_nxt = {w_lb1_rd, r_hist_top};
  assign w_mid_nxt = {w_lb0_rd, r_hist_mid};
  assign w_btm_nxt = {pix_data, r_hist_btm};

  // Line buffers: read-before-write, no reset (row gating hides stale contents)
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb1[w_c] <= w_lb0_rd;
      r_lb0[w_c] <= pix_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col        <= '0;
      r_row        <= '0;
      r_hist_top   <= '0;
      r_hist_mid   <= '0;
      r_hist_btm   <= '0;
      r_win_valid  <= 1'b0;
      r_win_row_0  <= '0;
      r_win_row_1  <= '0;
      r_win_row_2  <= '0;
      r_win_x      <= '0;
      r_win_y      <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= r_win_valid & win_ready &
                      (r_win_x == XW'(IMG_WIDTH - 2)) & (r_win_y == YW'(IMG_HEIGHT - 2));
      if (w_accept) begin
        r_col      <= w_col_nxt;
        r_row      <= w_row_nxt;
        r_hist_top <= w_top_nxt[23:8];
        r_hist_mid <= w_mid_nxt[23:8];
        r_hist_btm <= w_btm_nxt[23:8];
      end
      // Output stage is free whenever it is empty or being drained this cycle
      if (pix_ready) begin
        r_win_valid <= w_emit;
      end
      if (w_emit) begin
        r_win_row_0 <= w_top_nxt;
        r_win_row_1 <= w_mid_nxt;
        r_win_row_2 <= w_btm_nxt;
        r_win_x     <= w_c - XW'(1);
        r_win_y     <= w_r - YW'(1);
      end
    end
  end

  assign win_valid  = r_win_valid;
  assign win_row_0  = r_win_row_0;
  assign win_row_1  = r_win_row_1;
  assign win_row_2  = r_win_row_2;
  assign win_x      = r_win_x;
  assign win_y      = r_win_y;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_keypoint_window_gen.sv
// Bench for keypoint_window_gen: randomized frames with a 2-D image reference model feeding a
// window scoreboard, drained by an independent monitor.
module tb_keypoint_window_gen;
  localparam int unsigned W  = 5;
  localparam int unsigned H  = 4;
  localparam int unsigned XW = $clog2(W);
  localparam int unsigned YW = $clog2(H);

  logic          clk;
  logic          rst_n;
  logic          pix_valid;
  logic [7:0]    pix_data;
  logic          pix_sof;
  logic          pix_ready;
  logic          win_valid;
  logic          win_ready;
  logic [23:0]   win_row_0, win_row_1, win_row_2;
  logic [XW-1:0] win_x;
  logic [YW-1:0] win_y;
  logic          frame_done;

  keypoint_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_sof(pix_sof), .pix_ready(pix_ready), .win_valid(win_valid), .win_ready(win_ready),
    .win_row_0(win_row_0), .win_row_1(win_row_1), .win_row_2(win_row_2),
    .win_x(win_x), .win_y(win_y), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0]   r0;
    logic [23:0]   r1;
    logic [23:0]   r2;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } win_t;

  win_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  logic [7:0] img [H][W];
  int         mc = 0;
  int         mr = 0;
  bit         acc_now  = 1'b0;
  bit         emit_now = 1'b0;
  bit         rnd_ready = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: remember the image by coordinate; a window is the 3x3 block ending at (mc,mr)
  task automatic model_accept(input logic [7:0] d, input bit sof);
    win_t w;
    if (sof) begin
      mc = 0;
      mr = 0;
    end
    img[mr][mc] = d;
    emit_now = (mc >= 2) && (mr >= 2);
    if (emit_now) begin
      w.r0 = {img[mr-2][mc], img[mr-2][mc-1], img[mr-2][mc-2]};
      w.r1 = {img[mr-1][mc], img[mr-1][mc-1], img[mr-1][mc-2]};
      w.r2 = {img[mr][mc],   img[mr][mc-1],   img[mr][mc-2]};
      w.x  = XW'(mc - 1);
      w.y  = YW'(mr - 1);
      sb.push_back(w);
    end
    mc++;
    if (mc == W) begin
      mc = 0;
      mr = (mr == H - 1) ? 0 : mr + 1;
    end
  endtask

  task automatic send_px(input logic [7:0] d, input bit sof);
    bit done = 1'b0;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk); #1;
      pix_valid = 1'b1;
      pix_data  = d;
      pix_sof   = sof;
      win_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      acc_now  = pix_ready;
      emit_now = 1'b0;
      if (pix_ready) begin
        model_accept(d, sof);
        done = 1'b1;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL accept_timeout actual=no_accept required=accept at %0t", $time);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk); #1;
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
      win_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      acc_now  = 1'b0;
      emit_now = 1'b0;
    end
  endtask

  // kind 0: 16*r+c, kind 1: random, kind 2: flat 0x10 with 0x80 at (2,2)
  task automatic send_frame(input int kind, input bit sof_first);
    logic [7:0] d;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        case (kind)
          0:       d = 8'(16 * r + c);
          1:       d = 8'($urandom);
          default: d = (r == 2 && c == 2) ? 8'h80 : 8'h10;
        endcase
        send_px(d, sof_first && r == 0 && c == 0);
      end
    end
  endtask

  // Monitor: samples just before each rising edge, pops on every transfer
  initial begin
    bit   exp_valid = 1'b0;
    bit   exp_done  = 1'b0;
    bit   hold      = 1'b0;
    bit   xfer;
    win_t held, got, e;
    @(posedge clk);
    forever begin
      @(negedge clk); #3;
      got = {win_row_0, win_row_1, win_row_2, win_x, win_y};
      check("win_valid", 128'(win_valid), 128'(exp_valid));
      check("frame_done", 128'(frame_done), 128'(exp_done));
      check("pix_ready", 128'(pix_ready), 128'(!win_valid || win_ready));
      if (!rst_n) begin
        exp_valid = 1'b0;
        exp_done  = 1'b0;
        hold      = 1'b0;
      end else begin
        if (hold) check("stall_hold", 128'(got), 128'(held));
        hold = win_valid && !win_ready;
        held = got;
        xfer = win_valid && win_ready;
        exp_done = 1'b0;
        if (xfer) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_window actual=%0h required=none at %0t", got, $time);
          end else begin
            e = sb.pop_front();
            check("window", 128'(got), 128'(e));
            exp_done = (e.x == XW'(W - 2)) && (e.y == YW'(H - 2));
          end
        end
        exp_valid = acc_now ? emit_now : (xfer ? 1'b0 : exp_valid);
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    pix_data  = 8'h00;
    pix_sof   = 1'b0;
    win_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    send_frame(0, 1'b1);
    idle(3);

    rnd_ready = 1'b1;
    send_frame(0, 1'b1);
    idle(3);

    send_frame(1, 1'b1);
    send_frame(1, 1'b0);
    send_frame(1, 1'b1);
    idle(2);

    // Abandon a frame at (0,3); the next pixel (1,3) carries sof and restarts
    rnd_ready = 1'b0;
    for (int k = 0; k < 3 * W + 1; k++) send_px(8'($urandom), 1'b0);
    send_frame(0, 1'b1);
    idle(2);

    // Reset right after pixel (2,2) of a partial frame
    for (int k = 0; k < 2 * W + 3; k++) send_px(8'($urandom), 1'b0);
    @(negedge clk); #1;
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    win_ready = 1'b1;
    sb.delete();
    mc = 0;
    mr = 0;
    #1;
    acc_now  = 1'b0;
    emit_now = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    #1;
    send_frame(0, 1'b0);
    idle(3);

    rnd_ready = 1'b1;
    send_frame(2, 1'b1);
    idle(5);
    rnd_ready = 1'b0;
    idle(5);

    check("scoreboard_empty", 128'(sb.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
